// File: rtl/lights_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit OCI trace atoms into 30-bit DCT frames and hands them to the
// trace FIFO over a valid/ready handshake. Also raises a sticky
// test_has_ended once an end-of-test request has fully drained.
module lights_nios2_qsys_0_oci_dct_packer #(
    parameter int ATOM_W    = 2,
    parameter int MAX_ATOMS = 15,
    parameter int CNT_W     = 4,
    parameter int DROP_W    = 8,
    parameter int BUF_W     = ATOM_W * MAX_ATOMS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              atom_valid,
    input  logic [ATOM_W-1:0] atom_data,
    input  logic              flush,
    input  logic              test_ending,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [CNT_W-1:0]  dct_count,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
    output logic              test_has_ended
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(MAX_ATOMS);
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    state_t             state;
    logic [BUF_W-1:0]   acc;
    logic [CNT_W-1:0]   acc_cnt;
    logic               flush_pend;

    logic               out_free;
    logic               acc_full;
    logic               commit;
    logic               accept;
    logic               join_frame;
    logic               drop;
    logic [BUF_W-1:0]   acc_with_atom;
    logic [BUF_W-1:0]   acc_next;
    logic [CNT_W-1:0]   acc_cnt_next;
    logic [BUF_W-1:0]   frame_buf_next;
    logic [CNT_W-1:0]   frame_cnt_next;
    logic               flush_pend_next;

    // Next-state decode for the accumulator, commit path and flush request.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
        out_free        = !frame_valid || frame_ready;
        acc_full        = (acc_cnt == FULL_CNT);
        commit          = out_free && (acc_full || (flush_pend && (acc_cnt != '0)));
        accept          = atom_valid && (state == S_RUN);
        // A flush-driven commit of a non-full frame absorbs this cycle's atom.
        join_frame      = commit && accept && !acc_full;
        drop            = accept && acc_full && !commit;

        acc_with_atom   = acc;
        for (int k = 0; k < MAX_ATOMS; k++) begin
            if (CNT_W'(k) == acc_cnt)
                acc_with_atom[k*ATOM_W +: ATOM_W] = atom_data;
        end

        acc_next        = acc;
        acc_cnt_next    = acc_cnt;
        frame_buf_next  = join_frame ? acc_with_atom : acc;
        frame_cnt_next  = join_frame ? acc_cnt + 1'b1 : acc_cnt;

        if (commit) begin
            if (accept && acc_full) begin
                acc_next     = {{(BUF_W-ATOM_W){1'b0}}, atom_data};
                acc_cnt_next = CNT_W'(1);
            end else begin
                acc_next     = '0;
                acc_cnt_next = '0;
            end
        end else if (accept && !acc_full) begin
            acc_next     = acc_with_atom;
            acc_cnt_next = acc_cnt + 1'b1;
        end

        // A flush request only survives while there is something left to flush.
        flush_pend_next = ((flush_pend && !commit) || flush ||
                           ((state == S_RUN) && test_ending)) && (acc_cnt_next != '0);
    end

    // Registered datapath, output frame register, drop statistics and end-of-test FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_RUN;
            acc            <= '0;
            acc_cnt        <= '0;
            flush_pend     <= 1'b0;
            dct_buffer     <= '0;
            dct_count      <= '0;
            frame_valid    <= 1'b0;
            overflow       <= 1'b0;
            drop_count     <= '0;
            test_has_ended <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            acc        <= acc_next;
            acc_cnt    <= acc_cnt_next;
            flush_pend <= flush_pend_next;

            if (commit) begin
                dct_buffer  <= frame_buf_next;
                dct_count   <= frame_cnt_next;
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end

            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != DROP_MAX)
                    drop_count <= drop_count + 1'b1;
            end

            case (state)
                S_RUN: begin
                    if (test_ending)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // Empty accumulator and either no frame or the last one leaving now.
                    if ((acc_cnt == '0) && out_free)
                        state <= S_DONE;
                end
                S_DONE: begin
                    test_has_ended <= 1'b1;
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule
